// File: rtl/i2c_eeprom_seq.sv
// Byte-level sequencer for single-byte I2C EEPROM writes and random reads.
// It drives a byte engine through start/address/data phases and polls the
// device address to ride out the EEPROM internal write cycle.
module i2c_eeprom_seq #(
  parameter int unsigned RETRY_MAX = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [6:0]  dev_addr_i,
  input  logic [15:0] addr_i,
  input  logic [7:0]  wdata_i,
  output logic        gnt_o,
  output logic        rvalid_o,
  output logic        err_o,
  output logic [7:0]  rdata_o,
  output logic        busy_o,
  output logic        cmd_start_o,
  output logic        cmd_stop_o,
  output logic        cmd_write_o,
  output logic        cmd_read_o,
  output logic        cmd_ack_o,
  output logic [7:0]  cmd_din_o,
  input  logic        cmd_done_i,
  input  logic        cmd_rxack_i,
  input  logic [7:0]  cmd_dout_i
);

  localparam int unsigned CNT_W = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_DEV_W, S_ADDR_HI, S_ADDR_LO, S_WR_DATA,
    S_DEV_R, S_RD_DATA, S_ABORT, S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_we;
  logic [6:0]         r_dev;
  logic [15:0]        r_addr;
  logic [7:0]         r_wdata;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;
  logic               r_retry;
  logic [7:0]         r_rdata;

  logic               w_latch;
  logic               w_cnt_inc;
  logic               w_set_err;
  logic               w_ld_retry;
  logic               w_retry_val;
  logic               w_cap;
  logic [CNT_W-1:0]   w_cnt_nxt;

  // Saturating increment of the address-poll counter
  assign w_cnt_nxt = (r_cnt == CNT_W'(RETRY_MAX)) ? r_cnt : r_cnt + CNT_W'(1);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state and datapath control strobes
  always_comb begin
    w_next      = r_state;
    w_latch     = 1'b0;
    w_cnt_inc   = 1'b0;
    w_set_err   = 1'b0;
    w_ld_retry  = 1'b0;
    w_retry_val = 1'b0;
    w_cap       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_i) begin
          w_latch = 1'b1;
          w_next  = S_DEV_W;
        end
      end
      S_DEV_W: begin
        if (cmd_done_i) begin
          if (!cmd_rxack_i) begin
            w_next = S_ADDR_HI;
          end else begin
            w_cnt_inc   = 1'b1;
            w_ld_retry  = 1'b1;
            w_retry_val = (w_cnt_nxt < CNT_W'(RETRY_MAX));
            w_set_err   = ~w_retry_val;
            w_next      = S_ABORT;
          end
        end
      end
      S_ADDR_HI, S_ADDR_LO, S_WR_DATA, S_DEV_R: begin
        if (cmd_done_i) begin
          if (cmd_rxack_i) begin
            w_set_err  = 1'b1;
            w_ld_retry = 1'b1;
            w_next     = S_ABORT;
          end else begin
            case (r_state)
              S_ADDR_HI: w_next = S_ADDR_LO;
              S_ADDR_LO: w_next = r_we ? S_WR_DATA : S_DEV_R;
              S_WR_DATA: w_next = S_DONE;
              default:   w_next = S_RD_DATA;
            endcase
          end
        end
      end
      S_RD_DATA: begin
        if (cmd_done_i) begin
          w_cap  = 1'b1;
          w_next = S_DONE;
        end
      end
      S_ABORT: begin
        if (cmd_done_i) w_next = r_retry ? S_DEV_W : S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Transaction fields, retry bookkeeping, error flag and read data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_dev   <= 7'd0;
      r_addr  <= 16'd0;
      r_wdata <= 8'd0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_retry <= 1'b0;
      r_rdata <= 8'd0;
    end else begin
      if (w_latch) begin
        r_we    <= we_i;
        r_dev   <= dev_addr_i;
        r_addr  <= addr_i;
        r_wdata <= wdata_i;
        r_cnt   <= '0;
        r_err   <= 1'b0;
        r_retry <= 1'b0;
      end
      if (w_cnt_inc)  r_cnt   <= w_cnt_nxt;
      if (w_set_err)  r_err   <= 1'b1;
      if (w_ld_retry) r_retry <= w_retry_val;
      if (w_cap)      r_rdata <= cmd_dout_i;
    end
  end

  // Byte-engine command decode; depends on state only so it is stable per phase
  always_comb begin
    cmd_start_o = 1'b0;
    cmd_stop_o  = 1'b0;
    cmd_write_o = 1'b0;
    cmd_read_o  = 1'b0;
    cmd_ack_o   = 1'b0;
    cmd_din_o   = 8'h00;
    case (r_state)
      S_DEV_W: begin
        cmd_start_o = 1'b1;
        cmd_write_o = 1'b1;
        cmd_din_o   = {r_dev, 1'b0};
      end
      S_ADDR_HI: begin
        cmd_write_o = 1'b1;
        cmd_din_o   = r_addr[15:8];
      end
      S_ADDR_LO: begin
        cmd_write_o = 1'b1;
        cmd_din_o   = r_addr[7:0];
      end
      S_WR_DATA: begin
        cmd_write_o = 1'b1;
        cmd_stop_o  = 1'b1;
        cmd_din_o   = r_wdata;
      end
      S_DEV_R: begin
        cmd_start_o = 1'b1;
        cmd_write_o = 1'b1;
        cmd_din_o   = {r_dev, 1'b1};
      end
      S_RD_DATA: begin
        cmd_read_o = 1'b1;
        cmd_stop_o = 1'b1;
        cmd_ack_o  = 1'b1;
      end
      S_ABORT: cmd_stop_o = 1'b1;
      default: ;
    endcase
  end

  assign gnt_o    = (r_state == S_IDLE) & req_i;
  assign rvalid_o = (r_state == S_DONE);
  assign busy_o   = (r_state != S_IDLE);
  assign err_o    = r_err;
  assign rdata_o  = r_rdata;

endmodule
